wb_master_arbiter: RTL and testbench
====================================

// Module: wb_master_arbiter
// PURPOSE
//  Two-master Wishbone arbiter that shares the single 16-bit master port of the
//  wb_switch address decoder. Master 0 is the CPU; master 1 is a DMA or video fetch unit.
//  Grant is held for a whole cycle (cyc high), with round-robin fairness.
//  A watchdog releases the bus if a selected slave never acknowledges.
// PARAMETERS
//  TIMEOUT  64  slave cycles allowed with stb high and no ack before a forced ack; 0 disables
//  TO_W     7   watchdog counter width; must satisfy 2**TO_W > TIMEOUT
// PORTS
//  wb_clk_i      in   1   system clock; all logic is on the rising edge
//  wb_rst_i      in   1   synchronous reset, active high
//  mN_dat_i      in   16  write data from master N (N=0,1)
//  mN_dat_o      out  16  read data to master N; both masters see s_dat_i
//  mN_adr_i      in   20  word address [20:1] from master N
//  mN_sel_i      in   2   byte selects from master N
//  mN_we_i       in   1   write enable from master N
//  mN_cyc_i      in   1   bus request and cycle-valid from master N
//  mN_stb_i      in   1   strobe from master N
//  mN_ack_o      out  1   acknowledge to master N; only the granted master receives it
//  s_dat_o/i     out/in 16  write data to the switch / read data from the switch
//  s_adr_o       out  20  word address [20:1] to the switch
//  s_sel_o       out  2   byte selects to the switch
//  s_we_o        out  1   write enable to the switch
//  s_cyc_o       out  1   cycle to the switch
//  s_stb_o       out  1   strobe to the switch
//  s_ack_i       in   1   acknowledge from the switch
//  gnt_o         out  2   one-hot current grant; 00 when idle
//  timeout_o     out  1   one-cycle pulse when the watchdog forces an ack
// BEHAVIOUR
//  FSM states: IDLE, GNT0, GNT1. Registers: state, last (last granted master),
//   wd_cnt[TO_W-1:0].
//  Reset (synchronous, wins over everything, including mid-cycle):
//   state=IDLE, last=1, wd_cnt=0.
//   Outputs in IDLE: s_cyc_o=0, s_stb_o=0, s_we_o=0, s_adr_o=0, s_sel_o=0, s_dat_o=0,
//   m0_ack_o=0, m1_ack_o=0, gnt_o=00, timeout_o=0.
//  IDLE transitions:
//   - only m0_cyc_i -> GNT0; only m1_cyc_i -> GNT1.
//   - both requesting -> the master != last.
//   - no request -> stay in IDLE.
//   - Grant latency: request sampled at edge N; s_cyc_o is high in the cycle after edge N.
//  GNTk (k=0,1):
//   - s_* outputs are combinational copies of mk_* inputs; s_stb_o = mk_cyc_i & mk_stb_i.
//   - gnt_o[k]=1; last <= k on entry.
//   - Stay in GNTk while mk_cyc_i=1; no preemption.
//   - On mk_cyc_i=0 -> IDLE (s_cyc_o low that cycle). This gives at least one idle
//     cycle between grants.
//  Acks:
//   - mk_ack_o = gnt_o[k] & (s_ack_i | forced_ack).
//   - The non-granted master's ack is always 0; its stb is ignored.
//  Watchdog (TIMEOUT>0):
//   - wd_cnt increments each cycle with s_stb_o=1 & s_ack_i=0.
//   - wd_cnt clears on s_ack_i, on forced_ack, or when s_stb_o=0.
//   - forced_ack = (wd_cnt == TIMEOUT-1) & s_stb_o & ~s_ack_i. It is combinational,
//     lasts one cycle, and timeout_o equals forced_ack.
//   - If a real ack arrives in the same cycle, the real ack is used and there is no
//     timeout pulse.
//  Width rules: addresses and data pass through unmodified; no arithmetic beyond wd_cnt,
//   which never wraps because it clears at TIMEOUT-1.
//  Ack in IDLE: a stray s_ack_i is ignored.
//  Simultaneous events: a master dropping cyc in the same cycle as an ack gets that ack,
//   and the FSM moves to IDLE.
// TESTING
//  1. Reset, then m0 read of adr 20'h00400; slave acks 2 cycles after stb.
//     -> m0_ack_o pulses once, gnt_o=01, m1_ack_o=0 throughout.
//  2. m0 and m1 assert cyc on the same edge after reset.
//     -> m0 granted first; after m0 drops cyc, one idle cycle, then gnt_o=10.
//  3. m0 and m1 both request continuously, issuing back-to-back single cycles.
//     -> grants alternate 01,10,01,10; no master is granted twice in a row.
//  4. TIMEOUT=4; m1 strobes and the slave never acks.
//     -> m1_ack_o and timeout_o pulse in the 4th stb cycle; wd_cnt back to 0.
//  5. Slave acks in exactly the cycle wd_cnt==TIMEOUT-1.
//     -> a single ack, timeout_o stays 0.
//  6. Assert wb_rst_i mid-cycle while in GNT1.
//     -> next cycle s_cyc_o=0, gnt_o=00; after release m0 wins a tie.

Source files
------------

// File: rtl/wb_master_arbiter_if.sv
// Wishbone bus bundle (16-bit data, 20-bit word address) shared by masters, arbiter and switch.
// The master modport drives a request; the slave modport answers it.
interface wb_master_arbiter_if;
    logic [15:0] wdat;
    logic [15:0] rdat;
    logic [19:0] adr;
    logic [1:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        ack;

    modport master (output wdat, adr, sel, we, cyc, stb, input rdat, ack);
    modport slave  (input wdat, adr, sel, we, cyc, stb, output rdat, ack);
endinterface

// File: rtl/wb_master_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the wb_switch master port.
// Grant is held for a whole cyc; a watchdog forces an ack if the slave never answers.
module wb_master_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    wb_master_arbiter_if.slave          m0,
    wb_master_arbiter_if.slave          m1,
    wb_master_arbiter_if.master         s,
    output logic [1:0]                  gnt_o,
    output logic                        timeout_o
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    localparam bit            WD_EN     = (TIMEOUT > 0);
    localparam int            WD_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TO_W-1:0] WD_LAST = TO_W'(WD_LAST_I);

    state_t          state_reg;
    logic            last_reg;
    logic [1:0]      gnt_reg;
    logic [TO_W-1:0] wd_cnt_reg;
    logic            forced_ack;
    logic [1:0]      mst_ack;

    // A real ack in the same cycle always wins over the watchdog.
    assign forced_ack = WD_EN && (wd_cnt_reg == WD_LAST) && s.stb && !s.ack;
    assign timeout_o  = forced_ack;
    assign gnt_o      = gnt_reg;

    always_comb begin
        s.cyc  = 1'b0;
        s.stb  = 1'b0;
        s.we   = 1'b0;
        s.adr  = '0;
        s.sel  = '0;
        s.wdat = '0;
        case (state_reg)
            GNT0: begin
                s.cyc  = m0.cyc;
                s.stb  = m0.cyc & m0.stb;
                s.we   = m0.we;
                s.adr  = m0.adr;
                s.sel  = m0.sel;
                s.wdat = m0.wdat;
            end
            GNT1: begin
                s.cyc  = m1.cyc;
                s.stb  = m1.cyc & m1.stb;
                s.we   = m1.we;
                s.adr  = m1.adr;
                s.sel  = m1.sel;
                s.wdat = m1.wdat;
            end
            default: ;
        endcase
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_ack
        assign mst_ack[gi] = gnt_reg[gi] & (s.ack | forced_ack);
    end

    assign m0.ack  = mst_ack[0];
    assign m1.ack  = mst_ack[1];
    assign m0.rdat = s.rdat;
    assign m1.rdat = s.rdat;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg  <= IDLE;
            last_reg   <= 1'b1;
            gnt_reg    <= 2'b00;
            wd_cnt_reg <= '0;
        end else begin
            if (!WD_EN || !s.stb || s.ack || forced_ack)
                wd_cnt_reg <= '0;
            else
                wd_cnt_reg <= wd_cnt_reg + TO_W'(1);

            case (state_reg)
                IDLE: begin
                    // On a tie the master that did not hold the bus last wins.
                    if (m0.cyc && (!m1.cyc || last_reg)) begin
                        state_reg <= GNT0;
                        last_reg  <= 1'b0;
                        gnt_reg   <= 2'b01;
                    end else if (m1.cyc) begin
                        state_reg <= GNT1;
                        last_reg  <= 1'b1;
                        gnt_reg   <= 2'b10;
                    end
                end
                GNT0: begin
                    if (!m0.cyc) begin
                        state_reg <= IDLE;
                        gnt_reg   <= 2'b00;
                    end
                end
                GNT1: begin
                    if (!m1.cyc) begin
                        state_reg <= IDLE;
                        gnt_reg   <= 2'b00;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    gnt_reg   <= 2'b00;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_master_arbiter.sv
// Scoreboard bench for wb_master_arbiter: stimulus queues expected acks and grants,
// a monitor pops and compares whenever the arbiter presents an ack or a new grant.
module tb_wb_master_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] gnt;
    logic       tmo;

    wb_master_arbiter_if mi0();
    wb_master_arbiter_if mi1();
    wb_master_arbiter_if sb();

    wb_master_arbiter #(.TIMEOUT(4), .TO_W(3)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .m0       (mi0),
        .m1       (mi1),
        .s        (sb),
        .gnt_o    (gnt),
        .timeout_o(tmo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] adr;
        logic        we;
        logic [1:0]  sel;
        logic [15:0] wdat;
        logic [15:0] rdat;
        logic        to;
        int          wt;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [1:0] gq[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         delay = -1;
    logic       force_ack = 1'b0;
    int         cnt = 0;

    // Slave model: read data is a fixed function of the address.
    assign sb.rdat = sb.adr[15:0] ^ 16'hA5A5;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int k, input logic c, input logic [19:0] adr, input logic we,
                         input logic [15:0] wdat, input logic [1:0] sel);
        if (k == 0) begin
            mi0.cyc = c; mi0.stb = c; mi0.adr = adr; mi0.we = we; mi0.wdat = wdat; mi0.sel = sel;
        end else begin
            mi1.cyc = c; mi1.stb = c; mi1.adr = adr; mi1.we = we; mi1.wdat = wdat; mi1.sel = sel;
        end
    endtask

    task automatic do_xfer(input int k, input logic [19:0] adr, input logic we,
                           input logic [15:0] wdat, input logic [1:0] sel,
                           input logic [15:0] rdat, input logic to, input int wt);
        exp_t e;
        logic got;
        int   n;
        e = '{adr: adr, we: we, sel: sel, wdat: wdat, rdat: rdat, to: to, wt: wt};
        if (k == 0) q0.push_back(e); else q1.push_back(e);
        drive(k, 1'b1, adr, we, wdat, sel);
        got = 1'b0;
        n = 0;
        while (!got && n < 60) begin
            @(negedge clk);
            got = (k == 0) ? mi0.ack : mi1.ack;
            n++;
            @(posedge clk); #1;
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL xfer_wait m%0d adr=%h: no ack within %0d cycles", k, adr, n);
            if (k == 0) void'(q0.pop_back()); else void'(q1.pop_back());
        end else begin
            $display("xfer m%0d adr=%h we=%b done after %0d cycles", k, adr, we, n);
        end
        drive(k, 1'b0, adr, we, wdat, sel);
        @(posedge clk); #1;
    endtask

    // Slave responder: acks once the strobe has been held for 'delay' cycles; -1 never acks.
    initial begin
        sb.ack = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (sb.stb && !sb.ack && !tmo) cnt++; else cnt = 0;
            @(posedge clk); #2;
            sb.ack = force_ack || (delay >= 0 && sb.stb && cnt == delay);
        end
    end

    // Monitor: compares each ack and each new grant against the queued expectations.
    initial begin
        logic [1:0] prev_gnt;
        exp_t       e;
        prev_gnt = 2'b00;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                if (mi0.ack && mi1.ack) begin
                    n_vec++; n_err++;
                    $display("FAIL both_ack: got m0_ack=1 m1_ack=1 required at most one");
                end
                if (tmo && !(mi0.ack || mi1.ack)) begin
                    n_vec++; n_err++;
                    $display("FAIL lone_timeout: got timeout_o=1 with no master ack");
                end
                if (mi0.ack || mi1.ack) begin
                    int k;
                    k = mi0.ack ? 0 : 1;
                    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_ack: got ack on m%0d required none at %0t", k, $time);
                    end else begin
                        e = (k == 0) ? q0.pop_front() : q1.pop_front();
                        chk("ack_adr",  32'(sb.adr), 32'(e.adr));
                        chk("ack_we",   32'(sb.we), 32'(e.we));
                        chk("ack_sel",  32'(sb.sel), 32'(e.sel));
                        chk("ack_wdat", 32'(sb.wdat), 32'(e.wdat));
                        chk("ack_rdat", 32'((k == 0) ? mi0.rdat : mi1.rdat), 32'(e.rdat));
                        chk("ack_timeout", 32'(tmo), 32'(e.to));
                        chk("ack_stb_cycles", 32'(cnt), 32'(e.wt));
                        chk("ack_gnt", 32'(gnt), (k == 0) ? 32'd1 : 32'd2);
                    end
                end
                if (gnt != 2'b00 && gnt != prev_gnt) begin
                    if (prev_gnt != 2'b00) begin
                        n_vec++; n_err++;
                        $display("FAIL no_idle: got gnt %b -> %b required an idle cycle", prev_gnt, gnt);
                    end
                    if (gq.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_gnt: got %b required no new grant", gnt);
                    end else begin
                        chk("gnt_seq", 32'(gnt), 32'(gq.pop_front()));
                    end
                end
            end
            prev_gnt = gnt;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish before 200000");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 20'hFFFFF, 1'b1, 16'hFFFF, 2'b11);
        drive(1, 1'b0, 20'hFFFFF, 1'b1, 16'hFFFF, 2'b11);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_cyc", 32'(sb.cyc), 0);
        chk("rst_s_stb", 32'(sb.stb), 0);
        chk("rst_s_we",  32'(sb.we), 0);
        chk("rst_s_adr", 32'(sb.adr), 0);
        chk("rst_s_sel", 32'(sb.sel), 0);
        chk("rst_s_dat", 32'(sb.wdat), 0);
        chk("rst_gnt",   32'(gnt), 0);
        chk("rst_tmo",   32'(tmo), 0);
        chk("rst_acks",  32'({mi0.ack, mi1.ack}), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Stray slave ack while idle must be ignored.
        @(posedge clk); #1;
        force_ack = 1'b1;
        @(negedge clk);
        chk("stray_ack", 32'({mi0.ack, mi1.ack}), 0);
        chk("stray_gnt", 32'(gnt), 0);
        @(posedge clk); #1;
        force_ack = 1'b0;
        @(posedge clk); #1;

        // Single m0 read, slave acks two cycles after stb; checks grant latency.
        delay = 2;
        gq.push_back(2'b01);
        fork
            do_xfer(0, 20'h00400, 1'b0, 16'h1234, 2'b11, 16'hA1A5, 1'b0, 2);
            begin
                @(negedge clk);
                chk("lat_before", 32'(sb.cyc), 0);
                @(negedge clk);
                chk("lat_after", 32'(sb.cyc), 1);
            end
        join

        // Fresh reset, simultaneous requests: m0 first, idle cycle, then m1.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        delay = 1;
        gq.push_back(2'b01);
        gq.push_back(2'b10);
        fork
            do_xfer(0, 20'h12345, 1'b1, 16'hBEEF, 2'b01, 16'h86E0, 1'b0, 1);
            do_xfer(1, 20'hABCDE, 1'b1, 16'hCAFE, 2'b10, 16'h197B, 1'b0, 1);
        join

        // Continuous contention: grants must alternate.
        delay = 0;
        gq.push_back(2'b01); gq.push_back(2'b10);
        gq.push_back(2'b01); gq.push_back(2'b10);
        fork
            begin
                do_xfer(0, 20'h00010, 1'b0, 16'h1111, 2'b11, 16'hA5B5, 1'b0, 0);
                do_xfer(0, 20'h00020, 1'b1, 16'h2222, 2'b11, 16'hA585, 1'b0, 0);
            end
            begin
                do_xfer(1, 20'h00030, 1'b0, 16'h3333, 2'b11, 16'hA595, 1'b0, 0);
                do_xfer(1, 20'h00040, 1'b1, 16'h4444, 2'b11, 16'hA5E5, 1'b0, 0);
            end
        join

        // Silent slave: forced ack in the 4th stb cycle, twice to show the counter cleared.
        delay = -1;
        gq.push_back(2'b10);
        gq.push_back(2'b10);
        do_xfer(1, 20'h0F00F, 1'b0, 16'h5555, 2'b10, 16'h55AA, 1'b1, 3);
        do_xfer(1, 20'h0F00F, 1'b0, 16'h5555, 2'b10, 16'h55AA, 1'b1, 3);

        // Real ack lands exactly on the last watchdog cycle.
        delay = 3;
        gq.push_back(2'b01);
        do_xfer(0, 20'h00777, 1'b1, 16'h7777, 2'b01, 16'hA2D2, 1'b0, 3);

        // Reset in the middle of an m1 cycle, then a tie goes to m0.
        delay = -1;
        gq.push_back(2'b10);
        drive(1, 1'b1, 20'h22222, 1'b0, 16'h9999, 2'b11);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_gnt", 32'(gnt), 32'd2);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(0, 1'b1, 20'h00111, 1'b0, 16'h8888, 2'b11);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_s_cyc", 32'(sb.cyc), 0);
        chk("midrst_gnt", 32'(gnt), 0);
        chk("midrst_acks", 32'({mi0.ack, mi1.ack}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        delay = 0;
        gq.push_back(2'b01);
        gq.push_back(2'b10);
        fork
            do_xfer(0, 20'h00111, 1'b0, 16'h8888, 2'b11, 16'hA4B4, 1'b0, 0);
            do_xfer(1, 20'h22222, 1'b0, 16'h9999, 2'b11, 16'h8787, 1'b0, 0);
        join

        repeat (3) @(posedge clk);
        chk("left_q0", 32'(q0.size()), 0);
        chk("left_q1", 32'(q1.size()), 0);
        chk("left_gnt", 32'(gq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
